// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution slice.
// Holds the 4-bit ALUControl encodings, the execution FSM state type, the
// shift-amount width and a small helper that classifies the sequenced shifts.
package alu_pkg;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOr  = 4'b0011;
  localparam logic [3:0] AluSll = 4'b0100;
  localparam logic [3:0] AluSlt = 4'b0101;
  localparam logic [3:0] AluSrl = 4'b0110;
  localparam logic [3:0] AluSra = 4'b0111;
  localparam logic [3:0] AluSge = 4'b1000;
  localparam logic [3:0] AluXor = 4'b1001;

  localparam int unsigned ShamtW = 5;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } alu_state_e;

  // Shifts are executed one bit per cycle by the FSM, not by the comb core.
  function automatic logic is_shift_op(input logic [3:0] code);
    return (code == AluSll) || (code == AluSrl) || (code == AluSra);
  endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Single-cycle ALU operations.
// Ports:
//   alu_control - 4-bit operation code (alu_pkg encodings)
//   src_a/src_b - operands
//   result      - operation result; 0 for shift codes and illegal codes
//   illegal     - 1 for codes outside the defined set
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  logic lt_signed;

  assign lt_signed = $signed(src_a) < $signed(src_b);

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (alu_control)
      AluAdd: result = src_a + src_b;
      AluSub: result = src_a - src_b;
      AluAnd: result = src_a & src_b;
      AluOr:  result = src_a | src_b;
      AluXor: result = src_a ^ src_b;
      AluSlt: result = {{(WIDTH-1){1'b0}}, lt_signed};
      AluSge: result = {{(WIDTH-1){1'b0}}, ~lt_signed};
      // Shifts are sequenced in the execution unit.
      AluSll, AluSrl, AluSra: result = '0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execution unit with valid/ready handshakes on both sides.
// Non-shift operations complete in one cycle through alu_comb_core; shifts
// move one bit per cycle, so a shift by N takes N+1 cycles.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   in_valid / in_ready        - operation handshake
//   ALUControl, SrcA, SrcB     - operation code and operands
//   RdIn                       - destination register tag carried to RdOut
//   out_valid / out_ready      - result handshake
//   ALUResult, Zero, RdOut     - result, result==0 flag, destination tag
//   IllegalOp                  - operation code was not a defined operation
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [4:0]       RdIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic [4:0]       RdOut,
  output logic             IllegalOp
);

  alu_state_e state_q, state_d;

  logic [WIDTH-1:0]  res_q, res_d;
  logic [4:0]        rd_q, rd_d;
  logic              ill_q, ill_d;
  logic [ShamtW-1:0] cnt_q, cnt_d;
  logic [3:0]        op_q, op_d;

  logic [WIDTH-1:0]  core_result;
  logic              core_illegal;
  logic [WIDTH-1:0]  shift_step;
  logic [ShamtW-1:0] shamt_in;
  logic              accept;
  logic              start_shift;
  alu_state_e        accept_state;

  alu_comb_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .alu_control(ALUControl),
    .src_a      (SrcA),
    .src_b      (SrcB),
    .result     (core_result),
    .illegal    (core_illegal)
  );

  assign shamt_in     = SrcB[ShamtW-1:0];
  assign accept       = in_valid & in_ready;
  // A zero-amount shift needs no stepping and completes like a 1-cycle op.
  assign start_shift  = is_shift_op(ALUControl) && (shamt_in != '0);
  assign accept_state = start_shift ? StShift : StDone;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = accept_state;
      end
      StShift: begin
        // Last step: counter goes from 1 to 0 on this edge.
        if (cnt_q == ShamtW'(1)) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = accept ? accept_state : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle:  in_ready = 1'b1;
      StShift: in_ready = 1'b0;
      StDone: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // One-bit shift of the value in flight.
  always_comb begin
    shift_step = res_q;
    case (op_q)
      AluSll:  shift_step = {res_q[WIDTH-2:0], 1'b0};
      AluSrl:  shift_step = {1'b0, res_q[WIDTH-1:1]};
      AluSra:  shift_step = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
      default: shift_step = res_q;
    endcase
  end

  // Datapath next-state: operands are captured only on accept, so input
  // changes while shifting cannot disturb the result.
  always_comb begin
    res_d = res_q;
    rd_d  = rd_q;
    ill_d = ill_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    if (accept) begin
      op_d = ALUControl;
      rd_d = RdIn;
      if (is_shift_op(ALUControl)) begin
        res_d = SrcA;
        cnt_d = shamt_in;
        ill_d = 1'b0;
      end else begin
        res_d = core_result;
        cnt_d = '0;
        ill_d = core_illegal;
      end
    end else if (state_q == StShift) begin
      res_d = shift_step;
      cnt_d = cnt_q - ShamtW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      rd_q  <= '0;
      ill_q <= 1'b0;
      cnt_q <= '0;
      op_q  <= '0;
    end else begin
      res_q <= res_d;
      rd_q  <= rd_d;
      ill_q <= ill_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
    end
  end

  assign ALUResult = res_q;
  assign Zero      = (res_q == '0);
  assign RdOut     = rd_q;
  assign IllegalOp = ill_q;

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-002 The module SHALL have port clk, input, 1, the single clock, with all state updating on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 The module SHALL have port in_valid, input, 1, meaning an operation is presented.
REQ-005 The module SHALL have port in_ready, output, 1, meaning the unit can accept an operation this cycle.
REQ-006 The module SHALL have port ALUControl, input, 4, the operation code from the ALU decoder.
REQ-007 The module SHALL have ports SrcA and SrcB, input, WIDTH each, the operands.
REQ-008 The module SHALL have port RdIn, input, 5, the destination register tag.
REQ-009 The module SHALL have port out_valid, output, 1, meaning a result is held.
REQ-010 The module SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 The module SHALL have ports ALUResult (output, WIDTH), Zero (output, 1), RdOut (output, 5) and IllegalOp (output, 1).

Function
REQ-012 The unit SHALL accept an operation only on a cycle where in_valid and in_ready are both 1, capturing ALUControl, SrcA, SrcB and RdIn.
REQ-013 The unit SHALL decode ALUControl as follows:
- 0000 add; 0001 sub; 0010 and; 0011 or; 0100 sll; 0101 slt (signed, result 1 or 0).
- 0110 srl; 0111 sra; 1000 sge (signed SrcA>=SrcB, result 1 or 0); 1001 xor.
REQ-014 All arithmetic SHALL wrap modulo 2^WIDTH, with no carry or overflow output.
REQ-015 The unit SHALL be an FSM with three states: IDLE, SHIFT and DONE.
REQ-016 In IDLE, an accepted non-shift operation SHALL move the FSM to DONE with its result registered, giving a latency of 1 cycle.
REQ-017 Shift operations (sll, srl, sra) SHALL take the shift amount from SrcB[4:0] and ignore the upper bits of SrcB.
REQ-018 If the shift amount is 0, the FSM SHALL go directly to DONE with ALUResult equal to SrcA.
REQ-019 If the shift amount N is greater than 0, the FSM SHALL enter SHIFT and shift by 1 bit per cycle, with a counter decrementing from N.
REQ-020 The FSM SHALL enter DONE when the counter reaches 0, giving a total latency of N+1 cycles.
REQ-021 sra SHALL replicate the sign bit on each step; sll and srl SHALL fill with zero.
REQ-022 In DONE, out_valid SHALL be 1, and ALUResult, Zero, RdOut and IllegalOp SHALL be held stable until out_ready is 1.
REQ-023 Zero SHALL be 1 exactly when ALUResult equals 0.
REQ-024 in_ready SHALL be 1 in IDLE, or in DONE while out_ready is 1; it SHALL be 0 in SHIFT.
REQ-025 In DONE with out_ready 1 and no new accept, the FSM SHALL return to IDLE and out_valid SHALL fall on the next cycle.
REQ-026 In DONE with out_ready 1 and in_valid 1, the unit SHALL accept back-to-back, with no idle cycle between operations.
REQ-027 For ALUControl codes 1010 to 1111, the unit SHALL complete with a latency of 1 cycle, ALUResult 0, Zero 1 and IllegalOp 1.
REQ-028 IllegalOp SHALL be 0 for all legal codes.
REQ-029 in_valid SHALL be ignored while in_ready is 0, and input changes in SHIFT SHALL not affect the result in flight.

Reset
REQ-030 When rst_n is 0, the FSM SHALL be in IDLE, in_ready SHALL be 1, and out_valid, ALUResult, RdOut, IllegalOp and the counter SHALL be 0.
REQ-031 While rst_n is 0, Zero SHALL be 1, consistent with ALUResult being 0.
REQ-032 A reset asserted during SHIFT or DONE SHALL discard the operation in flight without producing a result.
REQ-033 After reset is released, the first rising edge SHALL be able to accept an operation.

Structure
REQ-034 A shared package alu_pkg SHALL hold:
- the 4-bit ALUControl code constants;
- the FSM state enum;
- the shift-amount width constant, 5.
REQ-035 The ALU decoder SHALL import the same alu_pkg code constants, so that a single encoding is used.
REQ-036 The combinational single-cycle operations SHALL be placed in one sub-module, alu_comb_core.
REQ-037 The FSM, the shift datapath and the handshake logic SHALL remain in alu_exec_unit.

Verification
REQ-038 Add: SrcA=0x7FFFFFFF, SrcB=1, code 0000, out_ready=1 -> after 1 cycle, ALUResult=0x80000000 and Zero=0.
REQ-039 Sub: SrcA=SrcB=0x1234, code 0001 -> ALUResult=0 and Zero=1, with RdOut echoing RdIn=5'd7.
REQ-040 Arithmetic shift: SrcA=0x80000000, SrcB=0x00000104, code 0111 -> in_ready=0 for 4 cycles, then ALUResult=0xF8000000 at latency 5.
REQ-041 Backpressure: hold out_ready=0 for 3 cycles after an slt of SrcA=-1 and SrcB=0 -> ALUResult=1 stays stable with out_valid=1 and in_ready=0.
REQ-042 Back-to-back: release out_ready with in_valid=1 on the same cycle -> the new op is accepted, and its result appears on the next cycle with no bubble.
REQ-043 Reset abort: assert rst_n=0 mid-shift (code 0100, shift amount 31) -> out_valid=0, and no result emerges after release.
